// File: rtl/store_queue_ctrl.sv
// Circular store buffer: holds speculative stores until retired, drains retired stores in order.
// Store-to-load forwarding is built only when SQ_FORWARD_EN is defined.
module store_queue_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned RET_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          in_location,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       store_stall,
    input  logic [RET_W-1:0]           retire_cnt,
    input  logic [ADDR_W-1:0]          search_location,
    output logic                       search_hit,
    output logic [DATA_W-1:0]          search_data,
    output logic                       mem_valid,
    output logic [ADDR_W-1:0]          mem_location,
    output logic [DATA_W-1:0]          mem_data,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] ret_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CMP_W = (RET_W > CNT_W) ? RET_W : CNT_W;

    logic [PTR_W-1:0]  head_q, head_d, rptr_q, rptr_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d, ret_count_q, ret_count_d;
    logic [ADDR_W-1:0] loc_q  [DEPTH];
    logic [ADDR_W-1:0] loc_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic             enq, drain;
    logic [CNT_W-1:0] spec_cnt;
    logic [CMP_W-1:0] ret_req, spec_ext, ret_amt;

    assign store_stall = (count_q == CNT_W'(DEPTH));
    assign mem_valid   = (ret_count_q != '0);
    assign mem_location = mem_valid ? loc_q[head_q]  : '0;
    assign mem_data     = mem_valid ? data_q[head_q] : '0;
    assign count       = count_q;
    assign ret_count   = ret_count_q;

    always_comb begin
        enq      = in_valid && !store_stall && !flush;
        drain    = mem_valid && mem_ready;
        spec_cnt = count_q - ret_count_q;
        ret_req  = CMP_W'(retire_cnt);
        spec_ext = CMP_W'(spec_cnt);
        ret_amt  = (ret_req < spec_ext) ? ret_req : spec_ext;

        head_d      = head_q + PTR_W'(drain);
        rptr_d      = rptr_q + PTR_W'(ret_amt);
        ret_count_d = ret_count_q + CNT_W'(ret_amt) - CNT_W'(drain);
        // Flush keeps only retired entries: tail collapses onto the post-retire rptr.
        if (flush) begin
            tail_d  = rptr_d;
            count_d = ret_count_d;
        end else begin
            tail_d  = tail_q + PTR_W'(enq);
            count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
        end

        loc_d  = loc_q;
        data_d = data_q;
        if (enq) begin
            loc_d[tail_q]  = in_location;
            data_d[tail_q] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            rptr_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ret_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                loc_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            rptr_q      <= rptr_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ret_count_q <= ret_count_d;
            loc_q       <= loc_d;
            data_q      <= data_d;
        end
    end

`ifdef SQ_FORWARD_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        search_hit  = 1'b0;
        search_data = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (loc_q[idx] == search_location)) begin
                search_hit  = 1'b1;
                search_data = data_q[idx];
            end
        end
    end
`else
    logic unused_search;
    assign unused_search = ^search_location;
    assign search_hit    = 1'b0;
    assign search_data   = '0;
`endif

endmodule
